// File: rtl/jtag_dtm_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_dtm_tap_pkg
// Description : Shared definitions for the JTAG TAP / DTM block.
//               - TAP controller state encoding
//               - IR instruction codes
//               - DMI op and status codes
//               - DTMCS field positions and a helper that builds the word
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_dtm_tap_pkg;

  // IEEE 1149.1 TAP controller states
  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'ha,
    SH_IR  = 4'hb,
    EX1_IR = 4'hc,
    PAU_IR = 4'hd,
    EX2_IR = 4'he,
    UPD_IR = 4'hf
  } tap_state_e;

  // Instruction codes
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  // Value loaded into the IR shift register on Capture-IR
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  // DMI op / status codes
  localparam logic [1:0] DMI_OP_NOP    = 2'd0;
  localparam logic [1:0] DMI_STAT_OK   = 2'd0;
  localparam logic [1:0] DMI_STAT_BUSY = 2'd3;

  // DTMCS write-side control bits
  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;

  localparam logic [2:0] DTMCS_IDLE    = 3'd1;
  localparam logic [3:0] DTMCS_VERSION = 4'd1;

  // DTMCS capture word:
  // {14'b0, dmihardreset, dmireset, 0, idle, dmistat, abits, version}
  function automatic logic [31:0] dtmcs_word(input logic [1:0] dmistat,
                                             input logic [5:0] abits);
    return {14'b0, 1'b0, 1'b0, 1'b0, DTMCS_IDLE, dmistat, abits, DTMCS_VERSION};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pin_sync
// Description : Brings the asynchronous JTAG pins into the clk domain and
//               detects TCK edges.
// Ports       : clk, rst (async, active-low)
//               tck/tms/tdi   - raw JTAG pins
//               tck_rise/fall - single-clk pulses on synchronized TCK edges
//               tms_s/tdi_s   - synchronized TMS/TDI, aligned with tck_*
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [SYNC_STAGES-1:0] tck_q;
  logic [SYNC_STAGES-1:0] tms_q;
  logic [SYNC_STAGES-1:0] tdi_q;
  logic                   tck_d;

  // All three pins use the same depth so TMS/TDI seen at a tck_rise pulse
  // were sampled at the same instant as the TCK level that produced it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      tck_d <= 1'b0;
    end else begin
      tck_q <= {tck_q[SYNC_STAGES-2:0], tck};
      tms_q <= {tms_q[SYNC_STAGES-2:0], tms};
      tdi_q <= {tdi_q[SYNC_STAGES-2:0], tdi};
      tck_d <= tck_q[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_d;
  assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_d;
  assign tms_s    = tms_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jtag_dtm_tap.sv
`default_nettype none
// ============================================================================
// Module      : jtag_dtm_tap
// Description : JTAG TAP controller plus RISC-V style Debug Transport Module,
//               running entirely in the clk domain (TCK is oversampled).
// Ports       : clk, rst (async, active-low)
//               jtag_TCK/TMS/TDI in, jtag_TDO out
//               dm_req_*  - valid/ready DMI request {addr, data, op}
//               dm_resp_* - valid/ready DMI response {data, status}
//               ir_out    - current instruction register
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dtm_tap
  import jtag_dtm_tap_pkg::*;
#(
  parameter int              IR_BITS     = 5,
  parameter int              DMI_ABITS   = 6,
  parameter int              DMI_DBITS   = 32,
  parameter logic [31:0]     IDCODE_VAL  = 32'h1e200a6d,
  parameter int              SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           jtag_TCK,
  input  logic                           jtag_TMS,
  input  logic                           jtag_TDI,
  output logic                           jtag_TDO,
  output logic                           dm_req_valid,
  input  logic                           dm_req_ready,
  output logic [DMI_ABITS+DMI_DBITS+1:0] dm_req_data,
  input  logic                           dm_resp_valid,
  output logic                           dm_resp_ready,
  input  logic [DMI_DBITS+1:0]           dm_resp_data,
  output logic [IR_BITS-1:0]             ir_out
);

  localparam int DR_W = DMI_ABITS + DMI_DBITS + 2;

  localparam logic [IR_BITS-1:0] C_IDCODE = IR_BITS'(IR_IDCODE);
  localparam logic [IR_BITS-1:0] C_DTMCS  = IR_BITS'(IR_DTMCS);
  localparam logic [IR_BITS-1:0] C_DMI    = IR_BITS'(IR_DMI);
  localparam logic [IR_BITS-1:0] C_BYPASS = IR_BITS'(IR_BYPASS);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .tck      (jtag_TCK),
    .tms      (jtag_TMS),
    .tdi      (jtag_TDI),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  // --------------------------------------------------------------------------
  // TAP controller
  // --------------------------------------------------------------------------
  tap_state_e state, state_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          state <= TLR;
    else if (tck_rise) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      TLR:     state_n = tms_s ? TLR    : RTI;
      RTI:     state_n = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_n = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_n = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_n = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_n = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  state_n = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  state_n = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  state_n = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_n = tms_s ? TLR    : CAP_IR;
      CAP_IR:  state_n = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_n = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_n = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  state_n = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  state_n = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  state_n = tms_s ? SEL_DR : RTI;
      default: state_n = TLR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [IR_BITS-1:0]   ir, ir_sr;
  logic [DR_W-1:0]      dr_sr, dr_shifted, dr_capture;
  logic                 tdo;

  logic                 req_valid;
  logic [DR_W-1:0]      req_data;
  logic                 pending;       // request issued, response not yet seen
  logic                 busy;          // sticky busy error
  logic [DMI_ABITS-1:0] last_addr;
  logic [DMI_DBITS-1:0] resp_data;
  logic [1:0]           resp_status;

  logic [1:0]           dmi_status;
  logic                 upd_dr, dmi_upd, dtmcs_upd;

  assign dmi_status = (busy || pending) ? DMI_STAT_BUSY : resp_status;
  assign upd_dr     = tck_rise && (state == UPD_DR);
  assign dmi_upd    = upd_dr && (ir == C_DMI);
  assign dtmcs_upd  = upd_dr && (ir == C_DTMCS);

  // The DR shift register is shared by all instructions; TDI enters at the
  // MSB of the selected register's length so the LSB always feeds TDO.
  always_comb begin
    dr_shifted = '0;
    dr_capture = '0;
    case (ir)
      C_IDCODE: begin
        dr_shifted = {{(DR_W-32){1'b0}}, tdi_s, dr_sr[31:1]};
        dr_capture = DR_W'(IDCODE_VAL);
      end
      C_DTMCS: begin
        dr_shifted = {{(DR_W-32){1'b0}}, tdi_s, dr_sr[31:1]};
        dr_capture = DR_W'(dtmcs_word(busy ? DMI_STAT_BUSY : DMI_STAT_OK,
                                      6'(DMI_ABITS)));
      end
      C_DMI: begin
        dr_shifted = {tdi_s, dr_sr[DR_W-1:1]};
        dr_capture = {last_addr, resp_data, dmi_status};
      end
      C_BYPASS: begin
        dr_shifted = {{(DR_W-1){1'b0}}, tdi_s};
        dr_capture = '0;
      end
      default: begin
        dr_shifted = {{(DR_W-1){1'b0}}, tdi_s};
        dr_capture = '0;
      end
    endcase
  end

  // Scan path: shift registers, IR and TDO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir    <= C_IDCODE;
      ir_sr <= '0;
      dr_sr <= '0;
      tdo   <= 1'b0;
    end else begin
      if (tck_rise) begin
        case (state)
          CAP_DR:  dr_sr <= dr_capture;
          SH_DR:   dr_sr <= dr_shifted;
          CAP_IR:  ir_sr <= IR_BITS'(IR_CAPTURE);
          SH_IR:   ir_sr <= {tdi_s, ir_sr[IR_BITS-1:1]};
          UPD_IR:  ir    <= ir_sr;
          default: ;
        endcase
      end
      if (tck_fall) begin
        if (state == SH_DR)      tdo <= dr_sr[0];
        else if (state == SH_IR) tdo <= ir_sr[0];
        else                     tdo <= 1'b0;
      end
      if (state == TLR) ir <= C_IDCODE;
    end
  end

  // DMI request/response handshake. Later assignments take priority, so a
  // DTMCS hard reset wins over a same-cycle handshake completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid   <= 1'b0;
      req_data    <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      last_addr   <= '0;
      resp_data   <= '0;
      resp_status <= DMI_STAT_OK;
    end else begin
      if (req_valid && dm_req_ready) req_valid <= 1'b0;

      // A response with nothing outstanding (e.g. after a hard reset) is
      // accepted but discarded.
      if (pending && dm_resp_valid) begin
        pending     <= 1'b0;
        resp_data   <= dm_resp_data[DMI_DBITS+1:2];
        resp_status <= dm_resp_data[1:0];
      end

      if (dmi_upd && (dr_sr[1:0] != DMI_OP_NOP)) begin
        if (pending) begin
          busy <= 1'b1;
        end else begin
          req_valid <= 1'b1;
          req_data  <= dr_sr;
          pending   <= 1'b1;
          last_addr <= dr_sr[DR_W-1 -: DMI_ABITS];
        end
      end

      if (dtmcs_upd && dr_sr[DTMCS_DMIRESET_BIT]) busy <= 1'b0;
      if (dtmcs_upd && dr_sr[DTMCS_HARDRESET_BIT]) begin
        busy      <= 1'b0;
        pending   <= 1'b0;
        req_valid <= 1'b0;
      end

      if (state == TLR) busy <= 1'b0;
    end
  end

  assign jtag_TDO      = tdo;
  assign dm_req_valid  = req_valid;
  assign dm_req_data   = req_data;
  assign dm_resp_ready = 1'b1;
  assign ir_out        = ir;

endmodule
`default_nettype wire
